// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared types and constants for the interrupt entry/exit sequencer.
//   irq_state_t    : sequencer FSM states (IDLE, ENTRY, VECTOR, SERVICE)
//   VEC_BASE_DEF   : default address of vector 0
//   VEC_STRIDE_DEF : default byte spacing between vectors
//   ILR_REG        : register-file index of the interrupt link register (r31)
//   vec_addr()     : vector address for a source index, 32-bit wrapping
// -----------------------------------------------------------------------------
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    VECTOR  = 2'd2,
    SERVICE = 2'd3
  } irq_state_t;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0010;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0004;
  localparam logic [4:0]  ILR_REG        = 5'b11111;

  // base + id * stride, truncated to 32 bits so overflow wraps
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [31:0] id);
    logic [31:0] offset;
    offset = id * stride;
    return base + offset;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Fixed-priority encoder: the lowest set request index wins.
//   req_i   [NUM_IRQ] : request vector
//   valid_o [1]       : at least one request is set
//   idx_o   [ID_W]    : index of the winning request (0 when none)
// -----------------------------------------------------------------------------
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] req_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    idx_o
);

  // scan upward; once a hit is recorded, higher indices are ignored
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (req_i[i] && !valid_o) begin
        valid_o = 1'b1;
        idx_o   = ID_W'(i);
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// -----------------------------------------------------------------------------
// irq_sequencer
// Interrupt entry/exit sequencer for the 5-stage core. Captures rising edges
// on the request lines, arbitrates by fixed priority (lowest index first) and
// walks the pipeline through entry: flush + ILR write, then vector redirect,
// then blocks further entry until the handler's RET is decoded.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   irq[NUM_IRQ]        : raw request lines (rising edge = request)
//   mask_we, mask_wdata : per-source enable mask write
//   gie_we, gie_wdata   : global interrupt enable write
//   stall               : pipeline stalled this cycle
//   branch_in_flight    : decode resolving a branch this cycle
//   resume_pc[32]       : PC of oldest uncommitted instruction
//   reti                : RET through ILR decoded (pulse)
//   flush               : kill IF/ID/EX contents (ENTRY)
//   ilr_we, ilr_wdata   : ILR (r31) write port (ENTRY)
//   inter, vec_pc       : redirect qualifier and target (VECTOR)
//   irq_ack[NUM_IRQ]    : one-hot acknowledge, first ENTRY cycle only
//   in_service          : handler active (SERVICE)
//   active_id[ID_W]     : index of the source being serviced
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int                  NUM_IRQ    = 4,
  parameter logic [31:0]         VEC_BASE   = VEC_BASE_DEF,
  parameter logic [31:0]         VEC_STRIDE = VEC_STRIDE_DEF,
  parameter logic [NUM_IRQ-1:0]  RST_MASK   = '1,
  localparam int                 ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               gie_we,
  input  logic               gie_wdata,
  input  logic               stall,
  input  logic               branch_in_flight,
  input  logic [31:0]        resume_pc,
  input  logic               reti,
  output logic               flush,
  output logic               ilr_we,
  output logic [31:0]        ilr_wdata,
  output logic               inter,
  output logic [31:0]        vec_pc,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               in_service,
  output logic [ID_W-1:0]    active_id
);

  irq_state_t         state_q;

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] pending_d;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] mask_d;
  logic               gie_q;
  logic               gie_d;

  logic               flush_q;
  logic               ilr_we_q;
  logic [31:0]        ilr_wdata_q;
  logic               inter_q;
  logic [31:0]        vec_pc_q;
  logic [NUM_IRQ-1:0] irq_ack_q;
  logic               in_service_q;
  logic [ID_W-1:0]    active_id_q;

  logic [NUM_IRQ-1:0] edge_s;
  logic [NUM_IRQ-1:0] eligible_s;
  logic [NUM_IRQ-1:0] ack_onehot_s;
  logic               win_valid_s;
  logic [ID_W-1:0]    win_idx_s;
  logic               take_s;

  // edge detect, pending bookkeeping, mask/gie next values
  always_comb begin
    edge_s = irq & ~irq_q;
    // the ack clears its source, but an edge in the same cycle re-arms it
    pending_d = (pending_q & ~irq_ack_q) | edge_s;
    if (mask_we) begin
      mask_d = mask_wdata;
    end else begin
      mask_d = mask_q;
    end
    if (gie_we) begin
      gie_d = gie_wdata;
    end else begin
      gie_d = gie_q;
    end
    // decisions use the registered (pre-write) mask and gie
    eligible_s = pending_q & mask_q & {NUM_IRQ{gie_q}};
  end

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_prio (
    .req_i   (eligible_s),
    .valid_o (win_valid_s),
    .idx_o   (win_idx_s)
  );

  // one-hot acknowledge for the winner and the entry condition
  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_onehot_s[i] = (win_idx_s == ID_W'(i));
    end
    take_s = win_valid_s && !stall && !branch_in_flight;
  end

  // request capture and software-visible enable registers
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= RST_MASK;
      gie_q     <= 1'b0;
    end else begin
      irq_q     <= irq;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      gie_q     <= gie_d;
    end
  end

  // sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      flush_q      <= 1'b0;
      ilr_we_q     <= 1'b0;
      ilr_wdata_q  <= 32'h0000_0000;
      inter_q      <= 1'b0;
      vec_pc_q     <= 32'h0000_0000;
      irq_ack_q    <= '0;
      in_service_q <= 1'b0;
      active_id_q  <= '0;
    end else begin
      // ack is a single pulse; it is only re-raised on the IDLE->ENTRY edge
      irq_ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (take_s) begin
            state_q     <= ENTRY;
            flush_q     <= 1'b1;
            ilr_we_q    <= 1'b1;
            ilr_wdata_q <= resume_pc;
            active_id_q <= win_idx_s;
            irq_ack_q   <= ack_onehot_s;
          end else begin
            state_q <= IDLE;
          end
        end
        ENTRY: begin
          if (stall) begin
            state_q <= ENTRY;
          end else begin
            state_q  <= VECTOR;
            flush_q  <= 1'b0;
            ilr_we_q <= 1'b0;
            inter_q  <= 1'b1;
            vec_pc_q <= vec_addr(VEC_BASE, VEC_STRIDE, 32'(active_id_q));
          end
        end
        VECTOR: begin
          if (stall) begin
            state_q <= VECTOR;
          end else begin
            state_q      <= SERVICE;
            inter_q      <= 1'b0;
            in_service_q <= 1'b1;
          end
        end
        SERVICE: begin
          if (reti) begin
            state_q      <= IDLE;
            in_service_q <= 1'b0;
          end else begin
            state_q <= SERVICE;
          end
        end
        default: begin
          state_q      <= IDLE;
          flush_q      <= 1'b0;
          ilr_we_q     <= 1'b0;
          inter_q      <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign flush      = flush_q;
  assign ilr_we     = ilr_we_q;
  assign ilr_wdata  = ilr_wdata_q;
  assign inter      = inter_q;
  assign vec_pc     = vec_pc_q;
  assign irq_ack    = irq_ack_q;
  assign in_service = in_service_q;
  assign active_id  = active_id_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// -----------------------------------------------------------------------------
// tb_irq_sequencer
// Directed, table-driven bench for irq_sequencer (NUM_IRQ = 4, default
// vectors). Each table row gives the inputs for one cycle and the outputs
// expected just after the following rising edge.
// -----------------------------------------------------------------------------
module tb_irq_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic        gie_we;
  logic        gie_wdata;
  logic        stall;
  logic        branch_in_flight;
  logic [31:0] resume_pc;
  logic        reti;
  logic        flush;
  logic        ilr_we;
  logic [31:0] ilr_wdata;
  logic        inter;
  logic [31:0] vec_pc;
  logic [3:0]  irq_ack;
  logic        in_service;
  logic [1:0]  active_id;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  irq;
    logic        mwe;
    logic [3:0]  mwd;
    logic        gwe;
    logic        st;
    logic        bif;
    logic [31:0] rpc;
    logic        reti;
    logic [73:0] exp;
  } vec_t;

  vec_t tbl[$];

  irq_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .irq              (irq),
    .mask_we          (mask_we),
    .mask_wdata       (mask_wdata),
    .gie_we           (gie_we),
    .gie_wdata        (gie_wdata),
    .stall            (stall),
    .branch_in_flight (branch_in_flight),
    .resume_pc        (resume_pc),
    .reti             (reti),
    .flush            (flush),
    .ilr_we           (ilr_we),
    .ilr_wdata        (ilr_wdata),
    .inter            (inter),
    .vec_pc           (vec_pc),
    .irq_ack          (irq_ack),
    .in_service       (in_service),
    .active_id        (active_id)
  );

  always #5 clk = ~clk;

  // inputs: rst irq mwe mwd gwe stall bif rpc reti
  // expect: flush ilr_we ilr_wdata inter vec_pc irq_ack in_service active_id
  task automatic add(input logic r, input logic [3:0] i, input logic mwe, input logic [3:0] mwd,
                     input logic gwe, input logic st, input logic bif, input logic [31:0] rpc,
                     input logic rt, input logic fl, input logic we, input logic [31:0] wd,
                     input logic it, input logic [31:0] vp, input logic [3:0] ack,
                     input logic sv, input logic [1:0] id);
    vec_t v;
    v.rst = r; v.irq = i; v.mwe = mwe; v.mwd = mwd; v.gwe = gwe;
    v.st = st; v.bif = bif; v.rpc = rpc; v.reti = rt;
    v.exp = {fl, we, wd, it, vp, ack, sv, id};
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; irq = 4'b0000; mask_we = 1'b0; mask_wdata = 4'b0000;
    gie_we = 1'b0; gie_wdata = 1'b1; stall = 1'b0; branch_in_flight = 1'b0;
    resume_pc = 32'h0; reti = 1'b0;
  endtask

  initial begin
    logic [73:0] act;
    logic [3:0]  hirq;
    int          n;
    bit          seen;

    idle_inputs();

    // reset, then enable interrupts globally
    add(1,4'b0000,0,4'h0,0,0,0,32'h000,0, 0,0,32'h000,0,32'h00,4'b0000,0,2'd0);  // 0
    add(0,4'b0000,0,4'h0,1,0,0,32'h000,0, 0,0,32'h000,0,32'h00,4'b0000,0,2'd0);  // 1
    // single request on source 2
    add(0,4'b0100,0,4'h0,0,0,0,32'h120,0, 0,0,32'h000,0,32'h00,4'b0000,0,2'd0);  // 2 edge
    add(0,4'b0100,0,4'h0,0,0,0,32'h120,0, 1,1,32'h120,0,32'h00,4'b0100,0,2'd2);  // 3 ENTRY
    add(0,4'b0100,0,4'h0,0,0,0,32'h000,0, 0,0,32'h120,1,32'h18,4'b0000,0,2'd2);  // 4 VECTOR
    add(0,4'b0100,0,4'h0,0,0,0,32'h000,0, 0,0,32'h120,0,32'h18,4'b0000,1,2'd2);  // 5 SERVICE
    add(0,4'b0100,0,4'h0,0,0,0,32'h000,0, 0,0,32'h120,0,32'h18,4'b0000,1,2'd2);  // 6
    add(0,4'b0100,0,4'h0,0,0,0,32'h000,1, 0,0,32'h120,0,32'h18,4'b0000,0,2'd2);  // 7 reti
    add(0,4'b0000,0,4'h0,0,0,0,32'h000,0, 0,0,32'h120,0,32'h18,4'b0000,0,2'd2);  // 8
    // priority: sources 3 and 1 together
    add(0,4'b1010,0,4'h0,0,0,0,32'h000,0, 0,0,32'h120,0,32'h18,4'b0000,0,2'd2);  // 9
    add(0,4'b1010,0,4'h0,0,0,0,32'h200,0, 1,1,32'h200,0,32'h18,4'b0010,0,2'd1);  // 10
    add(0,4'b1010,0,4'h0,0,0,0,32'h000,0, 0,0,32'h200,1,32'h14,4'b0000,0,2'd1);  // 11
    add(0,4'b1010,0,4'h0,0,0,0,32'h000,0, 0,0,32'h200,0,32'h14,4'b0000,1,2'd1);  // 12
    add(0,4'b1010,0,4'h0,0,0,0,32'h000,1, 0,0,32'h200,0,32'h14,4'b0000,0,2'd1);  // 13 reti
    add(0,4'b1010,0,4'h0,0,0,0,32'h300,0, 1,1,32'h300,0,32'h14,4'b1000,0,2'd3);  // 14
    add(0,4'b1010,0,4'h0,0,0,0,32'h000,0, 0,0,32'h300,1,32'h1C,4'b0000,0,2'd3);  // 15
    add(0,4'b1010,0,4'h0,0,0,0,32'h000,0, 0,0,32'h300,0,32'h1C,4'b0000,1,2'd3);  // 16
    add(0,4'b0000,0,4'h0,0,0,0,32'h000,1, 0,0,32'h300,0,32'h1C,4'b0000,0,2'd3);  // 17
    // deferral: branch in flight x3, stall x2, stalls inside ENTRY/VECTOR
    add(0,4'b0001,0,4'h0,0,0,0,32'h000,0, 0,0,32'h300,0,32'h1C,4'b0000,0,2'd3);  // 18
    for (int k = 0; k < 3; k++)
      add(0,4'b0001,0,4'h0,0,0,1,32'h000,0, 0,0,32'h300,0,32'h1C,4'b0000,0,2'd3);
    for (int k = 0; k < 2; k++)
      add(0,4'b0001,0,4'h0,0,1,0,32'h000,0, 0,0,32'h300,0,32'h1C,4'b0000,0,2'd3);
    add(0,4'b0001,0,4'h0,0,0,0,32'h400,0, 1,1,32'h400,0,32'h1C,4'b0001,0,2'd0);  // 24 ENTRY
    add(0,4'b0001,0,4'h0,0,1,0,32'h000,0, 1,1,32'h400,0,32'h1C,4'b0000,0,2'd0);  // 25 held
    add(0,4'b0001,0,4'h0,0,0,0,32'h000,0, 0,0,32'h400,1,32'h10,4'b0000,0,2'd0);  // 26
    add(0,4'b0001,0,4'h0,0,1,0,32'h000,0, 0,0,32'h400,1,32'h10,4'b0000,0,2'd0);  // 27 held
    add(0,4'b0001,0,4'h0,0,0,0,32'h000,0, 0,0,32'h400,0,32'h10,4'b0000,1,2'd0);  // 28
    add(0,4'b0000,0,4'h0,0,0,0,32'h000,1, 0,0,32'h400,0,32'h10,4'b0000,0,2'd0);  // 29
    // masking of source 0, then unmask
    add(0,4'b0000,1,4'hE,0,0,0,32'h000,0, 0,0,32'h400,0,32'h10,4'b0000,0,2'd0);  // 30
    for (int k = 0; k < 3; k++)
      add(0,4'b0001,0,4'h0,0,0,0,32'h000,0, 0,0,32'h400,0,32'h10,4'b0000,0,2'd0);
    add(0,4'b0001,1,4'hF,0,0,0,32'h000,0, 0,0,32'h400,0,32'h10,4'b0000,0,2'd0);  // 34 write
    add(0,4'b0001,0,4'h0,0,0,0,32'h500,0, 1,1,32'h500,0,32'h10,4'b0001,0,2'd0);  // 35
    add(0,4'b0001,0,4'h0,0,0,0,32'h000,0, 0,0,32'h500,1,32'h10,4'b0000,0,2'd0);  // 36
    add(0,4'b0001,0,4'h0,0,0,0,32'h000,0, 0,0,32'h500,0,32'h10,4'b0000,1,2'd0);  // 37
    add(0,4'b0000,0,4'h0,0,0,0,32'h000,1, 0,0,32'h500,0,32'h10,4'b0000,0,2'd0);  // 38
    // new edge on source 2 coincides with its ack cycle
    add(0,4'b0100,0,4'h0,0,0,0,32'h000,0, 0,0,32'h500,0,32'h10,4'b0000,0,2'd0);  // 39
    add(0,4'b0000,0,4'h0,0,0,0,32'h600,0, 1,1,32'h600,0,32'h10,4'b0100,0,2'd2);  // 40
    add(0,4'b0100,0,4'h0,0,0,0,32'h000,0, 0,0,32'h600,1,32'h18,4'b0000,0,2'd2);  // 41 re-edge
    add(0,4'b0100,0,4'h0,0,0,0,32'h000,0, 0,0,32'h600,0,32'h18,4'b0000,1,2'd2);  // 42
    add(0,4'b0100,0,4'h0,0,0,0,32'h000,1, 0,0,32'h600,0,32'h18,4'b0000,0,2'd2);  // 43
    add(0,4'b0100,0,4'h0,0,0,0,32'h700,0, 1,1,32'h700,0,32'h18,4'b0100,0,2'd2);  // 44 again
    add(0,4'b0100,0,4'h0,0,0,0,32'h000,0, 0,0,32'h700,1,32'h18,4'b0000,0,2'd2);  // 45
    add(0,4'b0100,0,4'h0,0,0,0,32'h000,0, 0,0,32'h700,0,32'h18,4'b0000,1,2'd2);  // 46
    add(0,4'b0100,0,4'h0,0,0,0,32'h000,1, 0,0,32'h700,0,32'h18,4'b0000,0,2'd2);  // 47
    add(0,4'b0100,0,4'h0,0,0,0,32'h000,1, 0,0,32'h700,0,32'h18,4'b0000,0,2'd2);  // 48 reti idle
    add(0,4'b0100,0,4'h0,0,0,0,32'h000,0, 0,0,32'h700,0,32'h18,4'b0000,0,2'd2);  // 49
    // reset during VECTOR with source 0 pending
    add(0,4'b1000,0,4'h0,0,0,0,32'h000,0, 0,0,32'h700,0,32'h18,4'b0000,0,2'd2);  // 50
    add(0,4'b1000,0,4'h0,0,0,0,32'h800,0, 1,1,32'h800,0,32'h18,4'b1000,0,2'd3);  // 51
    add(0,4'b1001,0,4'h0,0,0,0,32'h000,0, 0,0,32'h800,1,32'h1C,4'b0000,0,2'd3);  // 52
    add(1,4'b0000,0,4'h0,0,0,0,32'h000,0, 0,0,32'h000,0,32'h00,4'b0000,0,2'd0);  // 53 rst
    add(0,4'b0100,0,4'h0,0,0,0,32'h000,0, 0,0,32'h000,0,32'h00,4'b0000,0,2'd0);  // 54 gie=0
    add(0,4'b0100,0,4'h0,1,0,0,32'h000,0, 0,0,32'h000,0,32'h00,4'b0000,0,2'd0);  // 55
    add(0,4'b0100,0,4'h0,0,0,0,32'h900,0, 1,1,32'h900,0,32'h00,4'b0100,0,2'd2);  // 56
    add(0,4'b0100,0,4'h0,0,0,0,32'h000,0, 0,0,32'h900,1,32'h18,4'b0000,0,2'd2);  // 57
    add(0,4'b0100,0,4'h0,0,0,0,32'h000,0, 0,0,32'h900,0,32'h18,4'b0000,1,2'd2);  // 58
    add(0,4'b0100,0,4'h0,0,0,0,32'h000,1, 0,0,32'h900,0,32'h18,4'b0000,0,2'd2);  // 59

    for (int k = 0; k < tbl.size(); k++) begin
      rst = tbl[k].rst; irq = tbl[k].irq; mask_we = tbl[k].mwe; mask_wdata = tbl[k].mwd;
      gie_we = tbl[k].gwe; gie_wdata = 1'b1; stall = tbl[k].st;
      branch_in_flight = tbl[k].bif; resume_pc = tbl[k].rpc; reti = tbl[k].reti;
      step();
      act = {flush, ilr_we, ilr_wdata, inter, vec_pc, irq_ack, in_service, active_id};
      n_vec++;
      if (act !== tbl[k].exp) begin
        n_bad++;
        $display("FAIL vec%0d: got fl=%b we=%b wd=%h it=%b vp=%h ack=%b sv=%b id=%0d, expected fl=%b we=%b wd=%h it=%b vp=%h ack=%b sv=%b id=%0d",
                 k, act[73], act[72], act[71:40], act[39], act[38:7], act[6:3], act[2], act[1:0],
                 tbl[k].exp[73], tbl[k].exp[72], tbl[k].exp[71:40], tbl[k].exp[39],
                 tbl[k].exp[38:7], tbl[k].exp[6:3], tbl[k].exp[2], tbl[k].exp[1:0]);
      end
    end

    // hand-written: source 1 edge while source 2 line stays high, bounded wait
    idle_inputs();
    hirq = 4'b0110;
    irq = hirq;
    resume_pc = 32'h0000_0A00;
    n = 0;
    seen = 1'b0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      step();
      n = c;
      seen = flush;
    end
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL entry_timeout: no flush within 10 cycles, expected flush at cycle 2");
    end else begin
      chk("entry_latency", 32'(n), 32'd2);
      chk("entry_ack", 32'(irq_ack), 32'h2);
      chk("entry_ilr", ilr_wdata, 32'h0000_0A00);
      step();
      chk("vector_pc", vec_pc, 32'h14);
      chk("vector_inter", 32'(inter), 32'd1);
      step();
      chk("service", 32'(in_service), 32'd1);
      reti = 1'b1;
      step();
      reti = 1'b0;
      chk("reti_exit", 32'(in_service), 32'd0);
      step();
      chk("no_reentry", 32'(flush), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

Interrupt entry/exit sequencer for the 5-stage core. Latches edge-triggered interrupt requests, arbitrates them by fixed priority, and drives the decode stage through interrupt entry. Entry is a flush of the younger pipeline, a write of the resume PC into ILR (r31), and a redirect to the vector with the decode `inter` qualifier asserted. It then blocks further entry until the handler's return-from-interrupt is decoded.

## Interface
Parameters:
- `NUM_IRQ`, default 4: number of interrupt sources, 1..16.
- `VEC_BASE`, default 32'h0000_0010: address of vector 0.
- `VEC_STRIDE`, default 32'h0000_0004: byte spacing between vectors.
- `RST_MASK`, default all ones: per-source enable mask value after reset.

Ports:
- `clk`, in, 1: core clock. All logic is on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `irq`, in, NUM_IRQ: raw request lines. A rising edge makes a request.
- `mask_we`, in, 1: write enable for the mask register.
- `mask_wdata`, in, NUM_IRQ: new mask value. Bit = 1 enables the source.
- `gie_we`, in, 1: write enable for the global interrupt enable.
- `gie_wdata`, in, 1: new global interrupt enable value.
- `stall`, in, 1: pipeline stalled this cycle.
- `branch_in_flight`, in, 1: decode is resolving a Branch/notBranch this cycle.
- `resume_pc`, in, 32: PC of the oldest instruction not yet committed.
- `reti`, in, 1: one-cycle pulse when decode issues RET through ILR.
- `flush`, out, 1: kill the IF/ID/EX contents.
- `ilr_we`, out, 1: write enable for ILR.
- `ilr_wdata`, out, 32: value written to ILR.
- `inter`, out, 1: interrupt redirect qualifier to decode.
- `vec_pc`, out, 32: redirect target.
- `irq_ack`, out, NUM_IRQ: one-hot acknowledge pulse.
- `in_service`, out, 1: a handler is active.
- `active_id`, out, ID_W: index of the source being serviced. ID_W = max(1, $clog2(NUM_IRQ)).

## Operation
- **Edge detect.** `irq_q` holds `irq` delayed by one cycle. When `irq & ~irq_q` is set for a source, `pending[i]` is set.
- **Pending clear.** `pending[i]` clears on its `irq_ack` pulse. If a new edge arrives in the same cycle as the ack, the edge wins and `pending[i]` stays set.
- **Eligibility.** `eligible = pending & mask & {NUM_IRQ{gie}}`. The lowest index has highest priority.
- **Register writes.** `mask` and `gie` update on their write enables. The FSM decision in a given cycle uses the pre-write values.
- **IDLE.** Go to ENTRY when `eligible != 0 && !stall && !branch_in_flight`. Otherwise stay in IDLE.
- **ENTRY** (exactly 1 cycle):
  - Assert `flush = 1` and `ilr_we = 1`.
  - `ilr_wdata` is `resume_pc` registered on the IDLE→ENTRY transition.
  - Latch `active_id` = winning index.
  - Pulse `irq_ack[active_id]`.
  - Go to VECTOR.
- **VECTOR** (exactly 1 cycle):
  - Assert `inter = 1`.
  - `vec_pc = VEC_BASE + active_id * VEC_STRIDE`, computed in 32 bits with wrap on overflow.
  - Go to SERVICE.
- **SERVICE.**
  - `in_service = 1`. New pending edges are still recorded but are not taken.
  - On `reti = 1`, go to IDLE.
  - Writes to `gie`/`mask` take effect but cannot cause entry until the FSM is back in IDLE.
- **`reti` outside SERVICE.** Ignored.
- **`stall` in ENTRY or VECTOR.** The state and its outputs are held until `stall = 0`. `irq_ack` pulses only on the first cycle of ENTRY.

## Timing
- **Reset values:**
  - FSM = IDLE.
  - `pending` = 0, `irq_q` = 0, `mask` = RST_MASK, `gie` = 0.
  - `flush`, `ilr_we`, `inter`, `in_service`, `irq_ack` = 0.
  - `ilr_wdata`, `vec_pc`, `active_id` = 0.
- **Reset mid-sequence:** reset in any state returns to the reset values above on the next edge. No partial ack is produced.
- **Latency, no stall:**
  - Edge on `irq` at cycle N → `pending` set at N+1.
  - Earliest ENTRY at N+2, VECTOR at N+3, SERVICE at N+4.
- **Back-to-back sources:**
  - `reti` at cycle M → IDLE at M+1.
  - Earliest next ENTRY at M+2. A second source pending since SERVICE is therefore taken with a one-cycle IDLE gap.
- **Output registration:** all outputs are registered and decoded from state. There is no combinational path from inputs to outputs.

## Structure
- **Shared package `irq_pkg`:**
  - `irq_state_t` enum: IDLE, ENTRY, VECTOR, SERVICE.
  - Default constants: `VEC_BASE_DEF`, `VEC_STRIDE_DEF`, `ILR_REG = 5'b11111`.
- **Sub-module `irq_prio_enc`:** parameterised NUM_IRQ lowest-index priority encoder. Outputs a valid bit and an index.
- **Top:** the FSM, edge detect, pending/mask/gie registers, and output registers stay in the top module.

## Test plan
- **Single request.**
  - Stimulus: `gie` = 1, `irq[2]` rises, `resume_pc` = 32'h0000_0120.
  - Required: ENTRY with `flush = 1`, `ilr_we = 1`, `ilr_wdata = 32'h120`, `irq_ack = 4'b0100`. Then VECTOR with `inter = 1`, `vec_pc = 32'h0000_0018`. Then `in_service = 1`.
- **Priority.**
  - Stimulus: `irq[3]` and `irq[1]` rise in the same cycle.
  - Required: source 1 is serviced first (`vec_pc = 32'h14`). After `reti`, source 3 is taken two cycles later (`vec_pc = 32'h1C`).
- **Deferral.**
  - Stimulus: `pending[0]` set while `branch_in_flight = 1` for 3 cycles, then `stall = 1` for 2 cycles.
  - Required: ENTRY occurs only on the first cycle where both inputs are 0.
- **Masking.**
  - Stimulus: `mask = 4'b1110`, `irq[0]` rises.
  - Required: no entry while masked. After a `mask_we` write of 4'b1111, entry starts the cycle after the write.
- **Edge racing ack.**
  - Stimulus: `irq[2]` falls and re-rises so the new edge coincides with the ENTRY ack cycle.
  - Required: `pending[2]` remains 1 and is serviced again after `reti`. `reti` pulsed in IDLE causes no state change.
- **Reset mid-sequence.**
  - Stimulus: assert `rst` during VECTOR.
  - Required: next cycle FSM = IDLE, all outputs 0, `pending` = 0, `gie` = 0.
